tft43_reader: RTL

Read-side 8080 bus engine for the 4.3'' TFT panel. It issues one command write, releases the shared 16-bit data bus, then performs a programmable number of RD strobes and returns each sampled word. It sits beside the existing write-timing block on the same panel pins. The top level muxes bus ownership, and this block owns the pins only while `busy` is high.

---
 rtl/tft43_pkg.sv | 25 ++
 rtl/tft43_phase_timer.sv | 31 +++
 rtl/tft43_reader.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/tft43_pkg.sv
// Shared types and constants for the 4.3'' TFT 8080-bus read engine.
// Holds the phase enum, RS encodings, panel read-command codes and the phase timer width.
package tft43_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_LO,
    ST_CMD_HI,
    ST_TURN,
    ST_RD_LO,
    ST_RD_HI,
    ST_DONE
  } state_e;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam logic [15:0] CMD_RD_ID4    = 16'h00D3;
  localparam logic [15:0] CMD_RD_MADCTL = 16'h000B;
  localparam logic [15:0] CMD_RD_PIXFMT = 16'h000C;

  // Phase durations up to 256 cycles.
  localparam int TMR_W = 8;

endpackage

// File: rtl/tft43_phase_timer.sv
// Loadable down-counter shared by every timed bus phase.
// Load with (duration-1) on the entry transition; last is high in the final cycle of the phase.
module tft43_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/tft43_reader.sv
// 8080 read engine: one command write, bus turnaround, then rd_len RD strobes returning sampled words.
// Defining TFT43_RD_DUMMY_EN inserts one unreported dummy RD strobe ahead of the data strobes.
module tft43_reader
  import tft43_pkg::*;
#(
  parameter int WR_CYCLES      = 2,
  parameter int TURN_CYCLES    = 2,
  parameter int RD_LOW_CYCLES  = 4,
  parameter int RD_HIGH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] cmd,
  input  logic [7:0]  rd_len,
  output logic        busy,
  output logic [15:0] rdata,
  output logic        rdata_vld,
  output logic        done,
  output logic        LCD_CS,
  output logic        LCD_RS,
  output logic        LCD_WR,
  output logic        LCD_RD,
  output logic [15:0] LCD_DATA_O,
  output logic        LCD_DATA_OE,
  input  logic [15:0] LCD_DATA_I
);

`ifdef TFT43_RD_DUMMY_EN
  localparam logic DUMMY_EN = 1'b1;
`else
  localparam logic DUMMY_EN = 1'b0;
`endif

  localparam logic [TMR_W-1:0] WR_LD   = TMR_W'(WR_CYCLES - 1);
  localparam logic [TMR_W-1:0] TURN_LD = TMR_W'(TURN_CYCLES - 1);
  localparam logic [TMR_W-1:0] RDL_LD  = TMR_W'(RD_LOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] RDH_LD  = TMR_W'(RD_HIGH_CYCLES - 1);

  state_e             state_q, state_d;
  logic [15:0]        cmd_q, cmd_d;
  logic [15:0]        rdata_q, rdata_d;
  logic [7:0]         rem_q, rem_d;
  logic               dummy_q, dummy_d;
  logic               vld_q, vld_d;
  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_val;
  logic               tmr_last;

  tft43_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rem_d    = rem_q;
    dummy_d  = dummy_q;
    rdata_d  = rdata_q;
    vld_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_CMD_LO;
        cmd_d    = cmd;
        rem_d    = rd_len;
        dummy_d  = DUMMY_EN;
        tmr_load = 1'b1;
        tmr_val  = WR_LD;
      end
      ST_CMD_LO: if (tmr_last) begin
        state_d  = ST_CMD_HI;
        tmr_load = 1'b1;
        tmr_val  = WR_LD;
      end
      ST_CMD_HI: if (tmr_last) begin
        tmr_load = 1'b1;
        tmr_val  = TURN_LD;
        state_d  = (rem_q == 8'd0) ? ST_DONE : ST_TURN;
      end
      ST_TURN: if (tmr_last) begin
        state_d  = ST_RD_LO;
        tmr_load = 1'b1;
        tmr_val  = RDL_LD;
      end
      ST_RD_LO: if (tmr_last) begin
        state_d  = ST_RD_HI;
        tmr_load = 1'b1;
        tmr_val  = RDH_LD;
        if (!dummy_q) begin
          rdata_d = LCD_DATA_I;
          vld_d   = 1'b1;
        end
      end
      ST_RD_HI: if (tmr_last) begin
        tmr_load = 1'b1;
        tmr_val  = RDL_LD;
        // The dummy strobe never consumes a word from the count.
        if (dummy_q) begin
          dummy_d = 1'b0;
          state_d = ST_RD_LO;
        end else begin
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? ST_DONE : ST_RD_LO;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      rdata_q <= '0;
      rem_q   <= '0;
      dummy_q <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      rem_q   <= rem_d;
      dummy_q <= dummy_d;
      vld_q   <= vld_d;
    end
  end

  // Pin decode straight from the state flop so an async reset releases the bus at once.
  always_comb begin
    LCD_CS      = 1'b1;
    LCD_RS      = RS_DATA;
    LCD_WR      = 1'b1;
    LCD_RD      = 1'b1;
    LCD_DATA_OE = 1'b0;
    LCD_DATA_O  = '0;
    case (state_q)
      ST_CMD_LO, ST_CMD_HI: begin
        LCD_CS      = 1'b0;
        LCD_RS      = RS_CMD;
        LCD_DATA_OE = 1'b1;
        LCD_DATA_O  = cmd_q;
        LCD_WR      = (state_q == ST_CMD_HI);
      end
      ST_TURN, ST_RD_HI: LCD_CS = 1'b0;
      ST_RD_LO: begin
        LCD_CS = 1'b0;
        LCD_RD = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rdata     = rdata_q;
  assign rdata_vld = vld_q;

endmodule
